// File: rtl/alu_dst_gather.sv
// alu_dst_gather: gathers four 16-lane ALU result beats into one 64-lane result; `ALU_DST_GATHER_FLUSH_EN adds dest_flush
module alu_dst_gather #(
    parameter int DATA_WIDTH     = 32,
    parameter int LANES_PER_BEAT = 16,
    parameter int NUM_BEATS      = 4
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           alu_dest_valid,
    output logic                                           alu_dest_ready,
    input  logic [DATA_WIDTH*LANES_PER_BEAT-1:0]           alu_dest_data,
    input  logic [LANES_PER_BEAT-1:0]                      alu_dest_vcc_value,
    output logic                                           dest_valid,
    input  logic                                           dest_ready,
    output logic [DATA_WIDTH*LANES_PER_BEAT*NUM_BEATS-1:0] dest_data,
    output logic [LANES_PER_BEAT*NUM_BEATS-1:0]            dest_vcc_value,
    output logic [$clog2(NUM_BEATS)-1:0]                   dest_beat_cnt
`ifdef ALU_DST_GATHER_FLUSH_EN
    ,
    input  logic                                           dest_flush
`endif
);
    localparam int BW = DATA_WIDTH*LANES_PER_BEAT;
    localparam int CW = $clog2(NUM_BEATS);
    localparam logic [CW-1:0] LAST = CW'(NUM_BEATS-1);

    typedef enum logic {FILL, HOLD} state_t;

    state_t                                      state_q, state_d;
    logic [CW-1:0]                               cnt_q, cnt_d;
    logic [BW*NUM_BEATS-1:0]                     data_q, data_d;
    logic [LANES_PER_BEAT*NUM_BEATS-1:0]         vcc_q, vcc_d;
    logic                                        ready_q, valid_q;
    logic                                        flush, accept, handoff;

`ifdef ALU_DST_GATHER_FLUSH_EN
    assign flush = dest_flush;
`else
    assign flush = 1'b0;
`endif

    // Next state: a flush wins over everything, the last beat moves to HOLD, a handoff returns to FILL
    always_comb begin
        accept  = state_q == FILL && alu_dest_valid && !flush;
        handoff = state_q == HOLD && dest_ready;
        state_d = flush ? FILL : (accept && cnt_q == LAST) ? HOLD : handoff ? FILL : state_q;
        cnt_d   = flush ? '0 : !accept ? cnt_q : cnt_q == LAST ? '0 : cnt_q + 1'b1;
        data_d  = data_q;
        vcc_d   = vcc_q;
        if (accept) begin
            data_d[cnt_q*BW +: BW] = alu_dest_data;
            vcc_d[cnt_q*LANES_PER_BEAT +: LANES_PER_BEAT] = alu_dest_vcc_value;
        end
    end

    // State, slice registers and the registered handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
            cnt_q   <= '0;
            data_q  <= '0;
            vcc_q   <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            vcc_q   <= vcc_d;
            ready_q <= state_d == FILL;
            valid_q <= state_d == HOLD;
        end
    end

    assign alu_dest_ready = ready_q;
    assign dest_valid     = valid_q;
    assign dest_data      = data_q;
    assign dest_vcc_value = vcc_q;
    assign dest_beat_cnt  = cnt_q;
endmodule

// File: tb/tb_alu_dst_gather.sv
// tb_alu_dst_gather: directed checks of the 4-beat result gather
module tb_alu_dst_gather;
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          alu_dest_valid = 1'b0;
    logic          alu_dest_ready;
    logic [511:0]  alu_dest_data = '0;
    logic [15:0]   alu_dest_vcc_value = '0;
    logic          dest_valid;
    logic          dest_ready = 1'b0;
    logic [2047:0] dest_data;
    logic [63:0]   dest_vcc_value;
    logic [1:0]    dest_beat_cnt;
`ifdef ALU_DST_GATHER_FLUSH_EN
    logic          dest_flush = 1'b0;
`endif

    int checks = 0;
    int passes = 0;
    logic [2047:0] exp_data;

    alu_dst_gather dut (
        .clk(clk), .rst(rst),
        .alu_dest_valid(alu_dest_valid), .alu_dest_ready(alu_dest_ready),
        .alu_dest_data(alu_dest_data), .alu_dest_vcc_value(alu_dest_vcc_value),
        .dest_valid(dest_valid), .dest_ready(dest_ready),
        .dest_data(dest_data), .dest_vcc_value(dest_vcc_value),
        .dest_beat_cnt(dest_beat_cnt)
`ifdef ALU_DST_GATHER_FLUSH_EN
        , .dest_flush(dest_flush)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] mk(input logic [31:0] base);
        logic [511:0] d;
        for (int l = 0; l < 16; l++) d[32*l +: 32] = base + 32'(l);
        return d;
    endfunction

    task automatic drive(input logic v, input logic [31:0] base, input logic [15:0] vc);
        alu_dest_valid     = v;
        alu_dest_data      = mk(base);
        alu_dest_vcc_value = vc;
    endtask

    function automatic logic [2047:0] mk_all(input logic [31:0] base);
        logic [2047:0] d;
        for (int j = 0; j < 64; j++) d[32*j +: 32] = base + 32'(j);
        return d;
    endfunction

    logic pv [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    int   ec [7] = '{0, 1, 1, 2, 2, 2, 3};

    initial begin
        // reset values
        tick();
        tick();
        chk("rst_ready", 64'(alu_dest_ready), 64'd1);
        chk("rst_valid", 64'(dest_valid), 64'd0);
        chk("rst_cnt", 64'(dest_beat_cnt), 64'd0);
        chk("rst_data", 64'(dest_data === '0), 64'd1);
        chk("rst_vcc", dest_vcc_value, 64'd0);
        // reset mid-gather
        rst = 1'b0;
        drive(1'b1, 32'hDEAD_0000, 16'hFFFF);
        tick();
        tick();
        chk("mid_cnt", 64'(dest_beat_cnt), 64'd2);
        chk("mid_lane16", 64'(dest_data[32*16 +: 32]), 64'hDEAD_0000);
        alu_dest_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async_cnt", 64'(dest_beat_cnt), 64'd0);
        chk("async_valid", 64'(dest_valid), 64'd0);
        chk("async_data", 64'(dest_data === '0), 64'd1);
        chk("async_vcc", dest_vcc_value, 64'd0);
        #1 rst = 1'b0;
        tick();
        // basic gather: wavefront lane j carries value j
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'(16*k), 16'hA5A5 << k);
            tick();
            chk("basic_cnt", 64'(dest_beat_cnt), 64'((k + 1) % 4));
            chk("basic_valid", 64'(dest_valid), 64'(k == 3));
        end
        exp_data = mk_all(32'h0);
        chk("basic_lane17", 64'(dest_data[32*17 +: 32]), 64'h0000_0011);
        chk("basic_data", 64'(dest_data === exp_data), 64'd1);
        chk("basic_vcc", dest_vcc_value, 64'h2D28_9694_4B4A_A5A5);
        chk("basic_ready", 64'(alu_dest_ready), 64'd0);
        // back-pressure with a beat waiting
        drive(1'b1, 32'hC000_0000, 16'h0C0C);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("bp_ready", 64'(alu_dest_ready), 64'd0);
            chk("bp_valid", 64'(dest_valid), 64'd1);
            chk("bp_data", 64'(dest_data === exp_data), 64'd1);
        end
        // handoff collides with the waiting beat
        dest_ready = 1'b1;
        tick();
        chk("ho_valid", 64'(dest_valid), 64'd0);
        chk("ho_ready", 64'(alu_dest_ready), 64'd1);
        chk("ho_cnt", 64'(dest_beat_cnt), 64'd0);
        chk("ho_lane0_old", 64'(dest_data[31:0]), 64'd0);
        tick();
        chk("ho_cnt1", 64'(dest_beat_cnt), 64'd1);
        chk("ho_lane0_new", 64'(dest_data[31:0]), 64'hC000_0000);
        chk("ho_lane15", 64'(dest_data[32*15 +: 32]), 64'hC000_000F);
        chk("ho_lane16_old", 64'(dest_data[32*16 +: 32]), 64'd16);
        // dest_ready stays high through FILL without effect
        for (int k = 1; k < 4; k++) begin
            drive(1'b1, 32'hC000_0000 + 32'(16*k), 16'h0C0C);
            tick();
            chk("rdy_fill_cnt", 64'(dest_beat_cnt), 64'((k + 1) % 4));
        end
        chk("rdy_valid", 64'(dest_valid), 64'd1);
        chk("rdy_data", 64'(dest_data === mk_all(32'hC000_0000)), 64'd1);
        chk("rdy_vcc", dest_vcc_value, 64'h0C0C_0C0C_0C0C_0C0C);
        alu_dest_valid = 1'b0;
        tick();
        chk("rdy_ho_valid", 64'(dest_valid), 64'd0);
        chk("rdy_ho_ready", 64'(alu_dest_ready), 64'd1);
        // bubbles in alu_dest_valid
        dest_ready = 1'b0;
        begin
            int b = 0;
            for (int i = 0; i < 7; i++) begin
                chk("bub_cnt", 64'(dest_beat_cnt), 64'(ec[i]));
                if (pv[i]) begin
                    drive(1'b1, 32'hB000_0000 + 32'(16*b), 16'h1000 + 16'(b));
                    b++;
                end else begin
                    drive(1'b0, 32'hFFFF_0000, 16'hFFFF);
                end
                tick();
            end
        end
        alu_dest_valid = 1'b0;
        chk("bub_valid", 64'(dest_valid), 64'd1);
        chk("bub_data", 64'(dest_data === mk_all(32'hB000_0000)), 64'd1);
        chk("bub_vcc", dest_vcc_value, 64'h1003_1002_1001_1000);
        chk("bub_cnt_end", 64'(dest_beat_cnt), 64'd0);
`ifdef ALU_DST_GATHER_FLUSH_EN
        // flush a partial gather, then refill with all-ones beats
        dest_ready = 1'b1;
        tick();
        dest_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h1234_0000, 16'h1234);
            tick();
        end
        chk("fl_cnt3", 64'(dest_beat_cnt), 64'd3);
        drive(1'b1, 32'h5555_0000, 16'h5555);
        dest_flush = 1'b1;
        tick();
        dest_flush = 1'b0;
        chk("fl_cnt0", 64'(dest_beat_cnt), 64'd0);
        chk("fl_valid", 64'(dest_valid), 64'd0);
        chk("fl_lane48", 64'(dest_data[32*48 +: 32]), 64'hB000_0030);
        for (int k = 0; k < 4; k++) begin
            alu_dest_valid     = 1'b1;
            alu_dest_data      = '1;
            alu_dest_vcc_value = '1;
            tick();
            chk("fl_valid_once", 64'(dest_valid), 64'(k == 3));
        end
        alu_dest_valid = 1'b0;
        chk("fl_data", 64'(dest_data === '1), 64'd1);
        chk("fl_vcc", dest_vcc_value, 64'hFFFF_FFFF_FFFF_FFFF);
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
